// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state types for the transmitter and receiver.
// Optional macro UART_RX_PARITY_EN adds the receiver PARITY state.
package uart_pkg;

   localparam int SMP_SIZE_LOG = 4;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } uart_tx_state_t;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } uart_rx_state_t;
`else
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } uart_rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input; both flops reset
// to the idle-high line level so reset never looks like a start bit.
module uart_rx_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [1:0] sync_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], i_d};
      end
   end

   assign o_q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with valid/ack handshake, framing and overrun flags.
// Optional macro UART_RX_PARITY_EN enables an even-parity bit and o_parity_err.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_tick,
   input  logic            i_rx,
   input  logic            i_rx_ack,
   output logic [DBIT-1:0] o_dout,
   output logic            o_rx_valid,
   output logic            o_rx_busy,
   output logic            o_frame_err,
   output logic            o_overrun,
   output logic            o_parity_err
);

   // The stop phase may need more than 16 ticks (1.5 / 2 stop bits).
   localparam int CTR_W = ($clog2(SB_TICK) > SMP_SIZE_LOG) ? $clog2(SB_TICK) : SMP_SIZE_LOG;
   localparam int NB_W  = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [CTR_W-1:0] MID_START = CTR_W'(7);
   localparam logic [CTR_W-1:0] BIT_END   = CTR_W'(15);
   localparam logic [CTR_W-1:0] STOP_END  = CTR_W'(SB_TICK - 1);
   localparam logic [NB_W-1:0]  LAST_BIT  = NB_W'(DBIT - 1);

   logic             rx_s;
   uart_rx_state_t   state_q, state_d;
   logic [CTR_W-1:0] smp_ctr_q, smp_ctr_d;
   logic [NB_W-1:0]  n_bits_q, n_bits_d;
   logic [DBIT-1:0]  shreg_q, shreg_d;
   logic             done;

   logic [DBIT-1:0]  dout_q;
   logic             valid_q;
   logic             frame_err_q;
   logic             overrun_q;

`ifdef UART_RX_PARITY_EN
   logic             par_q, par_d;
   logic             parity_err_q;
`endif

   uart_rx_sync u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_rx),
      .o_q     (rx_s)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= RX_IDLE;
         smp_ctr_q <= '0;
         n_bits_q  <= '0;
         shreg_q   <= '0;
`ifdef UART_RX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         smp_ctr_q <= smp_ctr_d;
         n_bits_q  <= n_bits_d;
         shreg_q   <= shreg_d;
`ifdef UART_RX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      smp_ctr_d = smp_ctr_q;
      n_bits_d  = n_bits_q;
      shreg_d   = shreg_q;
      done      = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               state_d   = RX_START;
               smp_ctr_d = '0;
            end
         end
         RX_START: begin
            if (i_tick) begin
               if (smp_ctr_q == MID_START) begin
                  smp_ctr_d = '0;
                  // A line that is high again at mid start bit was only a glitch.
                  if (!rx_s) begin
                     state_d  = RX_DATA;
                     n_bits_d = '0;
                  end else begin
                     state_d = RX_IDLE;
                  end
               end else begin
                  smp_ctr_d = smp_ctr_q + CTR_W'(1);
               end
            end
         end
         RX_DATA: begin
            if (i_tick) begin
               if (smp_ctr_q == BIT_END) begin
                  smp_ctr_d = '0;
                  shreg_d   = {rx_s, shreg_q[DBIT-1:1]};
                  if (n_bits_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state_d = RX_PARITY;
`else
                     state_d = RX_STOP;
`endif
                  end else begin
                     n_bits_d = n_bits_q + NB_W'(1);
                  end
               end else begin
                  smp_ctr_d = smp_ctr_q + CTR_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         RX_PARITY: begin
            if (i_tick) begin
               if (smp_ctr_q == BIT_END) begin
                  smp_ctr_d = '0;
                  par_d     = rx_s;
                  state_d   = RX_STOP;
               end else begin
                  smp_ctr_d = smp_ctr_q + CTR_W'(1);
               end
            end
         end
`endif
         RX_STOP: begin
            if (i_tick) begin
               if (smp_ctr_q == STOP_END) begin
                  smp_ctr_d = '0;
                  state_d   = RX_IDLE;
                  done      = 1'b1;
               end else begin
                  smp_ctr_d = smp_ctr_q + CTR_W'(1);
               end
            end
         end
         default: begin
            state_d = RX_IDLE;
         end
      endcase
   end

   // A completing word takes priority over a simultaneous acknowledge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dout_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else if (done) begin
         dout_q       <= shreg_q;
         valid_q      <= 1'b1;
         frame_err_q  <= ~rx_s;
         overrun_q    <= valid_q & ~i_rx_ack;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= (^shreg_q) ^ par_q;
`endif
      end else if (i_rx_ack && valid_q) begin
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end
   end

   assign o_dout      = dout_q;
   assign o_rx_valid  = valid_q;
   assign o_rx_busy   = (state_q != RX_IDLE);
   assign o_frame_err = frame_err_q;
   assign o_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = parity_err_q;
`else
   assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level scoreboard plus directed literal checks.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx;

   localparam int DBIT    = 8;
   localparam int SB_TICK = 16;
   localparam int CPT     = 4;            // clocks per oversampling tick
   localparam int BIT_CLK = 16 * CPT;     // clocks per serial bit
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int PAR_TICKS   = PAR_EN ? 16 : 0;
   localparam int FRAME_TICKS = 8 + 16 * DBIT + PAR_TICKS + SB_TICK;
   localparam int FRAME_CLK   = (2 + DBIT) * BIT_CLK + PAR_TICKS * CPT;

   logic            i_clk   = 1'b0;
   logic            i_rst_n = 1'b0;
   logic            i_tick;
   logic            i_rx;
   logic            i_rx_ack;
   logic [DBIT-1:0] o_dout;
   logic            o_rx_valid;
   logic            o_rx_busy;
   logic            o_frame_err;
   logic            o_overrun;
   logic            o_parity_err;

   uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_tick       (i_tick),
      .i_rx         (i_rx),
      .i_rx_ack     (i_rx_ack),
      .o_dout       (o_dout),
      .o_rx_valid   (o_rx_valid),
      .o_rx_busy    (o_rx_busy),
      .o_frame_err  (o_frame_err),
      .o_overrun    (o_overrun),
      .o_parity_err (o_parity_err)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int tick_cnt = 0;

   typedef struct {
      logic [7:0] data;
      logic       ferr;
      logic       perr;
      int         deadline;
   } exp_t;
   exp_t exp_q[$];

   typedef struct packed {
      logic       valid;
      logic [7:0] dout;
      logic       ferr;
      logic       perr;
      logic       ovr;
   } obs_t;

   // Tick strobe: one clock high every CPT clocks.
   initial begin
      int phase;
      phase  = 0;
      i_tick = 1'b0;
      forever begin
         @(posedge i_clk);
         #1;
         phase  = (phase + 1) % CPT;
         i_tick = (phase == 0);
      end
   end

   initial begin
      forever begin
         @(posedge i_clk);
         cyc++;
         if (i_tick) tick_cnt++;
      end
   end

   function automatic logic exp_perr(input logic [7:0] d, input logic p);
      return PAR_EN ? ((^d) ^ p) : 1'b0;
   endfunction

   // Scoreboard: each cycle the outputs must either hold the previous
   // architectural state (with any sampled ack applied) or show the next
   // expected word landing.
   initial begin
      obs_t m, a, b, dut_s;
      logic ack_prev;
      m = '0;
      ack_prev = 1'b0;
      forever begin
         @(negedge i_clk);
         dut_s = {o_rx_valid, o_dout, o_frame_err, o_parity_err, o_overrun};
         if (!i_rst_n) begin
            m = '0;
            exp_q.delete();
            total++;
            if ({dut_s, o_rx_busy} !== '0) begin
               bad++;
               $display("FAIL reset_outputs: got %h busy=%b required 000 busy=0", dut_s, o_rx_busy);
            end
         end else begin
            a = m;
            if (ack_prev && m.valid) begin
               a.valid = 1'b0;
               a.ferr  = 1'b0;
               a.perr  = 1'b0;
               a.ovr   = 1'b0;
            end
            b = '0;
            if (exp_q.size() > 0) begin
               b.valid = 1'b1;
               b.dout  = exp_q[0].data;
               b.ferr  = exp_q[0].ferr;
               b.perr  = exp_q[0].perr;
               b.ovr   = m.valid & ~ack_prev;
            end
            total++;
            if (dut_s === a) begin
               m = a;
            end else if (exp_q.size() > 0 && dut_s === b) begin
               m = b;
               $display("rx word %02h ferr=%b perr=%b ovr=%b at cycle %0d",
                        b.dout, b.ferr, b.perr, b.ovr, cyc);
               void'(exp_q.pop_front());
            end else begin
               bad++;
               $display("FAIL scoreboard: cycle %0d got %h required %h (or %h on completion)",
                        cyc, dut_s, a, b);
               m = a;
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].deadline) begin
               total++;
               bad++;
               $display("FAIL frame_missing: word %02h not delivered by cycle %0d",
                        exp_q[0].data, exp_q[0].deadline);
               void'(exp_q.pop_front());
            end
         end
         ack_prev = i_rx_ack;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, got, req);
      end else begin
         $display("check %s: %0h", name, got);
      end
   endtask

   task automatic send_bit(input logic b);
      i_rx = b;
      repeat (BIT_CLK) @(posedge i_clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
      exp_t e;
      e.data     = d;
      e.ferr     = ~stop;
      e.perr     = exp_perr(d, par);
      e.deadline = cyc + FRAME_CLK;
      exp_q.push_back(e);
      $display("send frame data=%02h stop=%b par=%b", d, stop, par);
      send_bit(1'b0);
      for (int i = 0; i < DBIT; i++) send_bit(d[i]);
      if (PAR_EN) send_bit(par);
      send_bit(stop);
   endtask

   task automatic ack_pulse();
      i_rx_ack = 1'b1;
      @(posedge i_clk);
      #1;
      i_rx_ack = 1'b0;
      @(posedge i_clk);
      #1;
   endtask

   // Start entry is 3 clocks after the falling edge (2 sync + 1 IDLE->START);
   // the frame completes on the FRAME_TICKS-th tick after that.
   task automatic ack_on_completion();
      int base;
      int k;
      repeat (3) @(posedge i_clk);
      #1;
      base = tick_cnt;
      k = 0;
      while (tick_cnt != base + FRAME_TICKS - 1 && k < 4 * FRAME_TICKS) begin
         @(posedge i_clk);
         #1;
         k++;
      end
      if (k >= 4 * FRAME_TICKS) begin
         total++;
         bad++;
         $display("FAIL ack_timing: tick count %0d never reached %0d", tick_cnt, base + FRAME_TICKS - 1);
      end
      repeat (CPT - 1) @(posedge i_clk);
      #1;
      i_rx_ack = 1'b1;
      @(posedge i_clk);
      #1;
      i_rx_ack = 1'b0;
   endtask

   initial begin
      i_rx     = 1'b1;
      i_rx_ack = 1'b0;
      repeat (4) @(posedge i_clk);
      #1;
      check("reset_dout", 32'(o_dout), 0);
      check("reset_valid", 32'(o_rx_valid), 0);
      check("reset_busy", 32'(o_rx_busy), 0);
      check("reset_ferr", 32'(o_frame_err), 0);
      check("reset_ovr", 32'(o_overrun), 0);
      i_rst_n = 1'b1;
      repeat (4) @(posedge i_clk);
      #1;

      fork
         send_frame(8'hA5, 1'b1, 1'b0);
         begin
            repeat (100) @(posedge i_clk);
            #1;
            check("busy_in_frame", 32'(o_rx_busy), 1);
         end
      join
      check("a5_dout", 32'(o_dout), 32'h00A5);
      check("a5_valid", 32'(o_rx_valid), 1);
      check("a5_ferr", 32'(o_frame_err), 0);
      check("a5_perr", 32'(o_parity_err), 0);
      ack_pulse();
      check("a5_ack_valid", 32'(o_rx_valid), 0);

      i_rx = 1'b0;
      repeat (16) @(posedge i_clk);
      #1;
      check("glitch_busy", 32'(o_rx_busy), 1);
      i_rx = 1'b1;
      repeat (48) @(posedge i_clk);
      #1;
      check("glitch_idle", 32'(o_rx_busy), 0);
      check("glitch_valid", 32'(o_rx_valid), 0);

      send_frame(8'h3C, 1'b0, 1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      check("3c_dout", 32'(o_dout), 32'h003C);
      check("3c_ferr", 32'(o_frame_err), 1);
      check("3c_valid", 32'(o_rx_valid), 1);
      ack_pulse();
      check("3c_ack_ferr", 32'(o_frame_err), 0);

      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      check("ovr_dout", 32'(o_dout), 32'h0022);
      check("ovr_flag", 32'(o_overrun), 1);
      ack_pulse();
      check("ovr_ack", 32'(o_overrun), 0);

      send_frame(8'h11, 1'b1, 1'b0);
      fork
         send_frame(8'h22, 1'b1, 1'b0);
         ack_on_completion();
      join
      check("ackdone_dout", 32'(o_dout), 32'h0022);
      check("ackdone_valid", 32'(o_rx_valid), 1);
      check("ackdone_ovr", 32'(o_overrun), 0);

      $display("send aborted frame data=ff");
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      check("abort_busy", 32'(o_rx_busy), 1);
      i_rst_n = 1'b0;
      i_rx    = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      check("abort_valid", 32'(o_rx_valid), 0);
      check("abort_idle", 32'(o_rx_busy), 0);
      i_rst_n = 1'b1;
      send_bit(1'b1);
      send_bit(1'b1);
      send_frame(8'h5A, 1'b1, 1'b0);
      check("5a_dout", 32'(o_dout), 32'h005A);
      check("5a_valid", 32'(o_rx_valid), 1);
      ack_pulse();

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1);
      check("par_ok", 32'(o_parity_err), 0);
      ack_pulse();
      send_frame(8'h07, 1'b1, 1'b0);
      check("par_bad", 32'(o_parity_err), 1);
      check("par_dout", 32'(o_dout), 32'h0007);
      ack_pulse();
`endif

      repeat (10) @(posedge i_clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL pending_words: %0d expected words never delivered", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
